final_layer_chunked_argmax: RTL

//  Parametrised successor to the fixed 196-input/10-class final layer. Computes a per-class

---
 rtl/bnn_pkg.sv | 20 ++
 rtl/xnor_popcount.sv | 21 ++
 rtl/final_layer_chunked_argmax.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the BNN classifier output stage.
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

    // Argmax tie-break: a later class displaces the best only on a strictly greater score,
    // so equal scores resolve to the lowest class index.
    localparam bit TIE_LOWEST_INDEX = 1'b1;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width able to hold any count 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Masked XNOR-popcount of one W-bit chunk: counts positions where a matches b and mask is set.
module xnor_popcount
    import bnn_pkg::*;
#(
    parameter  int unsigned W     = 28,
    localparam int unsigned CNT_W = cnt_w(W)
) (
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     mask,
    output logic [CNT_W-1:0] count_c
);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            count_c = count_c + CNT_W'(~(a[i] ^ b[i]) & mask[i]);
        end
    end

endmodule

// File: rtl/final_layer_chunked_argmax.sv
// BNN final layer: chunked per-class XNOR-popcount scoring followed by a sequential argmax scan.
module final_layer_chunked_argmax
    import bnn_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS  = 196,
    parameter  int unsigned NUM_CLASSES = 10,
    parameter  int unsigned CHUNK       = 28,
    localparam int unsigned CLASS_W     = idx_w(NUM_CLASSES),
    localparam int unsigned SCORE_W     = cnt_w(NUM_INPUTS)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   en,
    input  logic [NUM_INPUTS-1:0]                  data_in,
    input  logic [NUM_CLASSES-1:0][NUM_INPUTS-1:0] weights_in,
    output logic [CLASS_W-1:0]                     answer,
    output logic [SCORE_W-1:0]                     best_score,
    output logic [SCORE_W-1:0]                     margin,
    output logic                                   busy,
    output logic                                   valid,
    output logic                                   layer_3_done
);

    localparam int unsigned NUM_CHUNKS  = (NUM_INPUTS + CHUNK - 1) / CHUNK;
    localparam int unsigned PAD_W       = NUM_CHUNKS * CHUNK;
    localparam int unsigned CHUNK_IDX_W = idx_w(NUM_CHUNKS);
    localparam int unsigned POP_W       = cnt_w(CHUNK);

    if (NUM_CLASSES < 2 || CHUNK < 1 || CHUNK > NUM_INPUTS) begin : g_bad_params
        $error("final_layer_chunked_argmax: need NUM_CLASSES>=2 and 1<=CHUNK<=NUM_INPUTS");
    end

    state_t                  state_q, state_d;
    logic                    armed_q, armed_d;
    logic                    start_c;
    logic [CHUNK_IDX_W-1:0]  chunk_q;
    logic [CLASS_W-1:0]      scan_q;
    logic [SCORE_W-1:0]      score_q [NUM_CLASSES];
    logic [SCORE_W-1:0]      best_q, second_q;
    logic [CLASS_W-1:0]      best_idx_q;

    logic [PAD_W-1:0]        data_pad, mask_pad;
    logic [31:0]             shamt;
    logic [CHUNK-1:0]        data_chunk, mask_chunk;
    logic [POP_W-1:0]        pop [NUM_CLASSES];
    logic [SCORE_W-1:0]      cur_score;
    logic                    beats_best;

    // Zero-extend to a whole number of chunks; the mask keeps padding bits from scoring.
    assign data_pad   = PAD_W'(data_in);
    assign mask_pad   = PAD_W'({NUM_INPUTS{1'b1}});
    assign shamt      = 32'(chunk_q) * CHUNK;
    assign data_chunk = CHUNK'(data_pad >> shamt);
    assign mask_chunk = CHUNK'(mask_pad >> shamt);

    for (genvar c = 0; c < int'(NUM_CLASSES); c++) begin : g_class
        logic [PAD_W-1:0] w_pad;
        logic [CHUNK-1:0] w_chunk;
        assign w_pad   = PAD_W'(weights_in[c]);
        assign w_chunk = CHUNK'(w_pad >> shamt);
        xnor_popcount #(.W(CHUNK)) u_xnor_popcount (
            .a       (data_chunk),
            .b       (w_chunk),
            .mask    (mask_chunk),
            .count_c (pop[c])
        );
    end

    assign cur_score  = score_q[scan_q];
    assign beats_best = TIE_LOWEST_INDEX ? (cur_score > best_q) : (cur_score >= best_q);

    // State and arming registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
        end
    end

    // Next state; en low at any time re-arms, a start consumes the arm.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        start_c = 1'b0;
        if (!en) armed_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (en && armed_q) begin
                    start_c = 1'b1;
                    armed_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM:   if (chunk_q == CHUNK_IDX_W'(NUM_CHUNKS - 1)) state_d = SCAN;
            SCAN:    if (scan_q == CLASS_W'(NUM_CLASSES - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: accumulate, scan, publish; results are published as DONE is left.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chunk_q      <= '0;
            scan_q       <= '0;
            best_q       <= '0;
            second_q     <= '0;
            best_idx_q   <= '0;
            answer       <= '0;
            best_score   <= '0;
            margin       <= '0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            layer_3_done <= 1'b0;
            for (int c = 0; c < int'(NUM_CLASSES); c++) score_q[c] <= '0;
        end else begin
            busy         <= (state_d != IDLE) || (state_q == DONE);
            layer_3_done <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        chunk_q <= '0;
                        scan_q  <= '0;
                        for (int c = 0; c < int'(NUM_CLASSES); c++) score_q[c] <= '0;
                    end
                end
                ACCUM: begin
                    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
                        score_q[c] <= score_q[c] + SCORE_W'(pop[c]);
                    end
                    chunk_q <= chunk_q + CHUNK_IDX_W'(1);
                end
                SCAN: begin
                    if (scan_q == '0) begin
                        best_q     <= cur_score;
                        best_idx_q <= '0;
                        second_q   <= '0;
                    end else if (beats_best) begin
                        second_q   <= best_q;
                        best_q     <= cur_score;
                        best_idx_q <= scan_q;
                    end else if (cur_score > second_q) begin
                        second_q   <= cur_score;
                    end
                    scan_q <= scan_q + CLASS_W'(1);
                end
                DONE: begin
                    answer     <= best_idx_q;
                    best_score <= best_q;
                    margin     <= best_q - second_q;
                    valid      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
